// File: rtl/mgia_pkg.sv
// Shared types and constants for the MGIA video RAM port.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: grant-owner enum, bus widths and byte-lane geometry used by the
// VRAM arbiter top level and its block-RAM sub-module.
package mgia_pkg;

  // Frame buffer geometry: 8K words of 16 monochrome pixels.
  localparam int MGIA_ADR_W = 13;
  localparam int MGIA_DAT_W = 16;

  // Byte lanes of a data word; SEL bit n enables lane n.
  localparam int MGIA_LANE_W = 8;
  localparam int MGIA_SEL_W  = MGIA_DAT_W / MGIA_LANE_W;
  localparam int LANE_LO     = 0;  // bits 7:0
  localparam int LANE_HI     = 1;  // bits 15:8

  // Owner of the RAM access issued at a clock edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VID  = 2'd1,
    CPU  = 2'd2
  } gnt_e;

endpackage

// File: rtl/mgia_vram_bram.sv
// Single-port 2**ADR_W x 16 synchronous RAM with byte write enables.
// Latency: read data registered, valid the cycle after the enabled edge.
// Backpressure: none; accepts one access every enabled clock edge.
//
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset of the read register only
//   en    - access enable for this edge
//   wr    - access is a write (read register holds its value)
//   be    - per-lane write enables, [1]=bits 15:8, [0]=bits 7:0
//   adr   - word address
//   wdat  - write data
//   rdat  - registered read data
module mgia_vram_bram
  import mgia_pkg::*;
#(
  parameter int ADR_W = MGIA_ADR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr,
  input  logic [MGIA_SEL_W-1:0] be,
  input  logic [ADR_W-1:0]      adr,
  input  logic [MGIA_DAT_W-1:0] wdat,
  output logic [MGIA_DAT_W-1:0] rdat
);

  localparam int DEPTH = 2 ** ADR_W;

  logic [MGIA_DAT_W-1:0] mem [0:DEPTH-1];
  logic [MGIA_DAT_W-1:0] rd_dat_q;

  // Write port: each lane is written independently so the synthesis tool
  // maps it onto the RAM's native byte-write enables. The contents are not
  // reset; only the access enable (driven low during reset) protects them.
  always_ff @(posedge clk) begin
    if (en && wr) begin
      for (int lane = 0; lane < MGIA_SEL_W; lane++) begin
        if (be[lane]) begin
          mem[adr][lane*MGIA_LANE_W +: MGIA_LANE_W] <= wdat[lane*MGIA_LANE_W +: MGIA_LANE_W];
        end
      end
    end
  end

  // Read register: loaded only by reads, so a write access leaves the last
  // read value on the output. The sync reset maps onto the BRAM output
  // register reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dat_q <= '0;
    end else if (en && !wr) begin
      rd_dat_q <= mem[adr];
    end
  end

  assign rdat = rd_dat_q;

endmodule

// File: rtl/mgia_vram_port.sv
// Dual-responder Wishbone port onto the MGIA frame-buffer RAM (video fetcher + CPU).
// Latency: grant at edge N, ACK and read data valid for exactly one cycle N..N+1.
// Backpressure: one RAM access per clock; video has priority, CPU gets a
//   starvation override after CPU_MAX_WAIT waiting cycles; a port is never
//   re-granted in its own ACK cycle.
//
// Ports:
//   CLK_I, RST_I                 - clock, synchronous active-high reset
//   V_ADR_I/V_CYC_I/V_STB_I      - video read request (read-only)
//   V_ACK_O/V_DAT_O              - video acknowledge pulse and read data
//   C_ADR_I/C_CYC_I/C_STB_I      - CPU request
//   C_WE_I/C_SEL_I/C_DAT_I       - CPU write enable, byte selects, write data
//   C_ACK_O/C_DAT_O              - CPU acknowledge pulse and read data
//   C_STARVE_O                   - sticky: CPU wait counter hit CPU_MAX_WAIT
//
// TEST_VID_B2B lets video be re-granted in its own ACK cycle so the CPU can
// be held off long enough to exercise the starvation override; it must stay
// 0 in real use.
module mgia_vram_port
  import mgia_pkg::*;
#(
  parameter int ADR_W        = MGIA_ADR_W,
  parameter int CPU_MAX_WAIT = 15,
  parameter bit TEST_VID_B2B = 1'b0
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic [ADR_W-1:0]      V_ADR_I,
  input  logic                  V_CYC_I,
  input  logic                  V_STB_I,
  output logic                  V_ACK_O,
  output logic [MGIA_DAT_W-1:0] V_DAT_O,
  input  logic [ADR_W-1:0]      C_ADR_I,
  input  logic                  C_CYC_I,
  input  logic                  C_STB_I,
  input  logic                  C_WE_I,
  input  logic [MGIA_SEL_W-1:0] C_SEL_I,
  input  logic [MGIA_DAT_W-1:0] C_DAT_I,
  output logic                  C_ACK_O,
  output logic [MGIA_DAT_W-1:0] C_DAT_O,
  output logic                  C_STARVE_O
);

  localparam int              WAIT_W   = 4;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

  gnt_e              gnt_q, gnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              starve_q, starve_d;

  logic              v_ack;
  logic              c_ack;
  logic              v_req;
  logic              c_req;

  logic                  ram_en;
  logic                  ram_wr;
  logic [ADR_W-1:0]      ram_adr;
  logic [MGIA_DAT_W-1:0] ram_rdat;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      gnt_q    <= IDLE;
      wait_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: request qualification, arbitration, wait counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // The grant register directly encodes who is being acknowledged now.
    v_ack = (gnt_q == VID);
    c_ack = (gnt_q == CPU);

    // Masking a port in its own ACK cycle stops a master that has not yet
    // dropped STB from being served twice, and guarantees the other port a
    // slot at least every second cycle.
    v_req = V_CYC_I && V_STB_I && (TEST_VID_B2B || !v_ack);
    c_req = C_CYC_I && C_STB_I && !c_ack;

    gnt_d = IDLE;
    if (c_req && (wait_q == WAIT_MAX)) begin
      gnt_d = CPU;
    end else if (v_req) begin
      gnt_d = VID;
    end else if (c_req) begin
      gnt_d = CPU;
    end

    // Wait counter tracks consecutive cycles of an unserved CPU request.
    wait_d = wait_q;
    if (!c_req || (gnt_d == CPU)) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
    end

    // Sticky: flags the same edge the counter reaches the limit.
    starve_d = starve_q || (wait_d == WAIT_MAX);
  end

  // ---------------------------------------------------------------------------
  // Output logic: RAM access for this edge and bus-facing outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // No access is issued on a reset edge, which also suppresses any CPU
    // write that would otherwise have been granted there.
    ram_en  = (gnt_d != IDLE) && !RST_I;
    ram_wr  = (gnt_d == CPU) && C_WE_I;
    ram_adr = (gnt_d == VID) ? V_ADR_I : C_ADR_I;

    V_ACK_O    = v_ack;
    C_ACK_O    = c_ack;
    // Both data outputs share the single RAM read register; each is only
    // meaningful while its own ACK is high.
    V_DAT_O    = ram_rdat;
    C_DAT_O    = ram_rdat;
    C_STARVE_O = starve_q;
  end

  mgia_vram_bram #(
    .ADR_W (ADR_W)
  ) u_bram (
    .clk  (CLK_I),
    .rst  (RST_I),
    .en   (ram_en),
    .wr   (ram_wr),
    .be   (C_SEL_I),
    .adr  (ram_adr),
    .wdat (C_DAT_I),
    .rdat (ram_rdat)
  );

endmodule

// File: tb/tb_mgia_vram_port.sv
module tb_mgia_vram_port;

  localparam int AW       = 13;
  localparam int MAX_WAIT = 15;

  logic        CLK_I;
  logic        RST_I;
  logic [AW-1:0] V_ADR_I;
  logic        V_CYC_I, V_STB_I, V_ACK_O;
  logic [15:0] V_DAT_O;
  logic [AW-1:0] C_ADR_I;
  logic        C_CYC_I, C_STB_I, C_WE_I, C_ACK_O, C_STARVE_O;
  logic [1:0]  C_SEL_I;
  logic [15:0] C_DAT_I, C_DAT_O;

  // Second instance with back-to-back video grants enabled.
  logic [AW-1:0] tm_v_adr, tm_c_adr;
  logic        tm_v_cyc, tm_v_stb, tm_v_ack;
  logic [15:0] tm_v_dat, tm_c_dat_i, tm_c_dat_o;
  logic        tm_c_cyc, tm_c_stb, tm_c_we, tm_c_ack, tm_c_starve;
  logic [1:0]  tm_c_sel;

  int checks = 0;
  int errors = 0;

  // Protocol counters for the normal-mode instance.
  int both_ack_cnt = 0;
  int long_ack_cnt = 0;
  logic v_ack_prev = 1'b0;
  logic c_ack_prev = 1'b0;

  logic [15:0] model_mem [0:(2**AW)-1];

  mgia_vram_port #(.ADR_W(AW), .CPU_MAX_WAIT(MAX_WAIT), .TEST_VID_B2B(1'b0)) u_dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .V_ADR_I(V_ADR_I), .V_CYC_I(V_CYC_I), .V_STB_I(V_STB_I), .V_ACK_O(V_ACK_O), .V_DAT_O(V_DAT_O),
    .C_ADR_I(C_ADR_I), .C_CYC_I(C_CYC_I), .C_STB_I(C_STB_I), .C_WE_I(C_WE_I), .C_SEL_I(C_SEL_I),
    .C_DAT_I(C_DAT_I), .C_ACK_O(C_ACK_O), .C_DAT_O(C_DAT_O), .C_STARVE_O(C_STARVE_O)
  );

  mgia_vram_port #(.ADR_W(AW), .CPU_MAX_WAIT(MAX_WAIT), .TEST_VID_B2B(1'b1)) u_tm (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .V_ADR_I(tm_v_adr), .V_CYC_I(tm_v_cyc), .V_STB_I(tm_v_stb), .V_ACK_O(tm_v_ack), .V_DAT_O(tm_v_dat),
    .C_ADR_I(tm_c_adr), .C_CYC_I(tm_c_cyc), .C_STB_I(tm_c_stb), .C_WE_I(tm_c_we), .C_SEL_I(tm_c_sel),
    .C_DAT_I(tm_c_dat_i), .C_ACK_O(tm_c_ack), .C_DAT_O(tm_c_dat_o), .C_STARVE_O(tm_c_starve)
  );

  initial CLK_I = 1'b0;
  always #20 CLK_I = ~CLK_I;

  always @(negedge CLK_I) begin
    if (V_ACK_O === 1'b1 && C_ACK_O === 1'b1) both_ack_cnt++;
    if ((V_ACK_O === 1'b1 && v_ack_prev === 1'b1) || (C_ACK_O === 1'b1 && c_ack_prev === 1'b1))
      long_ack_cnt++;
    v_ack_prev = V_ACK_O;
    c_ack_prev = C_ACK_O;
  end

  // Byte-lane merge as the bus defines it: selected lanes take new data.
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] sel);
    logic [15:0] r;
    r = old;
    if (sel[1]) r[15:8] = nw[15:8];
    if (sel[0]) r[7:0]  = nw[7:0];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK_I); #1;
    end
  endtask

  // One CPU transfer; lat = clock edges from request to observed ACK.
  task automatic cpu_xfer(input logic we, input logic [AW-1:0] adr, input logic [1:0] sel,
                          input logic [15:0] dat, output logic [15:0] rdat, output int lat);
    C_ADR_I = adr; C_WE_I = we; C_SEL_I = sel; C_DAT_I = dat;
    C_CYC_I = 1'b1; C_STB_I = 1'b1;
    lat = 0;
    forever begin
      @(posedge CLK_I); #1;
      lat++;
      if (C_ACK_O === 1'b1) break;
      if (lat >= 50) begin
        checks++; errors++;
        $display("FAIL cpu_ack_timeout adr=%h: no C_ACK_O, required within 50 cycles", adr);
        lat = -1;
        break;
      end
    end
    rdat = C_DAT_O;
    C_CYC_I = 1'b0; C_STB_I = 1'b0; C_WE_I = 1'b0;
    if (we && lat > 0) model_mem[adr] = merge(model_mem[adr], dat, sel);
  endtask

  task automatic vid_read(input logic [AW-1:0] adr, output logic [15:0] rdat, output int lat);
    V_ADR_I = adr; V_CYC_I = 1'b1; V_STB_I = 1'b1;
    lat = 0;
    forever begin
      @(posedge CLK_I); #1;
      lat++;
      if (V_ACK_O === 1'b1) break;
      if (lat >= 50) begin
        checks++; errors++;
        $display("FAIL vid_ack_timeout adr=%h: no V_ACK_O, required within 50 cycles", adr);
        lat = -1;
        break;
      end
    end
    rdat = V_DAT_O;
    V_CYC_I = 1'b0; V_STB_I = 1'b0;
  endtask

  task automatic test_reset;
    RST_I = 1'b1;
    tick(2);
    checks++; if (V_ACK_O !== 1'b0) begin errors++; $display("FAIL reset_v_ack got=%b exp=0", V_ACK_O); end
    checks++; if (C_ACK_O !== 1'b0) begin errors++; $display("FAIL reset_c_ack got=%b exp=0", C_ACK_O); end
    checks++; if (V_DAT_O !== 16'h0) begin errors++; $display("FAIL reset_v_dat got=%h exp=0000", V_DAT_O); end
    checks++; if (C_DAT_O !== 16'h0) begin errors++; $display("FAIL reset_c_dat got=%h exp=0000", C_DAT_O); end
    checks++; if (C_STARVE_O !== 1'b0) begin errors++; $display("FAIL reset_starve got=%b exp=0", C_STARVE_O); end
    RST_I = 1'b0;
    tick(1);
  endtask

  task automatic test_cpu_basic;
    logic [15:0] rd; int lat;
    cpu_xfer(1'b1, 13'h0010, 2'b11, 16'hBEEF, rd, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL cpu_wr_latency got=%0d exp=1", lat); end
    tick(1);
    checks++; if (C_ACK_O !== 1'b0) begin errors++; $display("FAIL cpu_wr_ack_width got=%b exp=0", C_ACK_O); end
    cpu_xfer(1'b0, 13'h0010, 2'b11, 16'h0, rd, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL cpu_rd_latency got=%0d exp=1", lat); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL cpu_rd_data got=%h exp=beef", rd); end
    tick(1);
    checks++; if (C_ACK_O !== 1'b0) begin errors++; $display("FAIL cpu_rd_ack_width got=%b exp=0", C_ACK_O); end
  endtask

  task automatic test_byte_lanes;
    logic [15:0] rd; int lat;
    cpu_xfer(1'b1, 13'd5, 2'b11, 16'h1234, rd, lat); tick(1);
    cpu_xfer(1'b1, 13'd5, 2'b10, 16'hAB00, rd, lat); tick(1);
    cpu_xfer(1'b0, 13'd5, 2'b11, 16'h0, rd, lat); tick(1);
    checks++; if (rd !== 16'hAB34) begin errors++; $display("FAIL lane_hi_write got=%h exp=ab34", rd); end
    cpu_xfer(1'b1, 13'd5, 2'b00, 16'hFFFF, rd, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL sel00_ack_latency got=%0d exp=1", lat); end
    checks++; if (rd !== 16'hAB34) begin errors++; $display("FAIL wr_keeps_rd_reg got=%h exp=ab34", rd); end
    tick(1);
    cpu_xfer(1'b0, 13'd5, 2'b11, 16'h0, rd, lat); tick(1);
    checks++; if (rd !== 16'hAB34) begin errors++; $display("FAIL sel00_no_change got=%h exp=ab34", rd); end
  endtask

  task automatic test_simultaneous;
    logic [15:0] vrd, crd; int vlat, clat;
    cpu_xfer(1'b1, 13'd1, 2'b11, 16'h1111, crd, clat); tick(1);
    cpu_xfer(1'b1, 13'd2, 2'b11, 16'h2222, crd, clat); tick(1);
    both_ack_cnt = 0;
    fork
      vid_read(13'd1, vrd, vlat);
      cpu_xfer(1'b0, 13'd2, 2'b11, 16'h0, crd, clat);
    join
    checks++; if (vlat != 1) begin errors++; $display("FAIL simul_v_latency got=%0d exp=1", vlat); end
    checks++; if (clat != 2) begin errors++; $display("FAIL simul_c_latency got=%0d exp=2", clat); end
    checks++; if (vrd !== 16'h1111) begin errors++; $display("FAIL simul_v_data got=%h exp=1111", vrd); end
    checks++; if (crd !== 16'h2222) begin errors++; $display("FAIL simul_c_data got=%h exp=2222", crd); end
    tick(1);
    checks++; if (both_ack_cnt != 0) begin errors++; $display("FAIL simul_both_ack got=%0d exp=0", both_ack_cnt); end
  endtask

  task automatic test_video_stream;
    logic [15:0] rd; int lat;
    int n, cyc, last, vbad, gapbad, cacks, cbad;
    logic vdone;
    for (int i = 0; i < 40; i++) begin
      cpu_xfer(1'b1, 13'h300 + 13'(i), 2'b11, 16'($urandom), rd, lat);
      tick(1);
    end
    n = 0; cyc = 0; last = 0; vbad = 0; gapbad = 0; cacks = 0; cbad = 0; vdone = 1'b0;
    both_ack_cnt = 0; long_ack_cnt = 0;
    fork
      begin
        V_ADR_I = 13'h300; V_CYC_I = 1'b1; V_STB_I = 1'b1;
        while (n < 40 && cyc < 400) begin
          @(posedge CLK_I); #1;
          cyc++;
          if (V_ACK_O === 1'b1) begin
            if (V_DAT_O !== model_mem[V_ADR_I]) vbad++;
            if (n > 0 && (cyc - last) != 2) gapbad++;
            last = cyc;
            n++;
            V_ADR_I = V_ADR_I + 13'd1;
          end
        end
        V_CYC_I = 1'b0; V_STB_I = 1'b0;
        vdone = 1'b1;
      end
      begin
        while (!vdone) begin
          cpu_xfer(1'b0, 13'h0010, 2'b11, 16'h0, rd, lat);
          if (lat < 0) break;
          cacks++;
          if (rd !== model_mem[13'h0010]) cbad++;
        end
      end
    join
    tick(1);
    checks++; if (n != 40) begin errors++; $display("FAIL stream_v_count got=%0d exp=40", n); end
    checks++; if (vbad != 0) begin errors++; $display("FAIL stream_v_data bad=%0d exp=0", vbad); end
    checks++; if (gapbad != 0) begin errors++; $display("FAIL stream_v_spacing bad=%0d exp=0", gapbad); end
    checks++; if (cacks < 39) begin errors++; $display("FAIL stream_c_interleave got=%0d exp>=39", cacks); end
    checks++; if (cbad != 0) begin errors++; $display("FAIL stream_c_data bad=%0d exp=0", cbad); end
    checks++; if (C_STARVE_O !== 1'b0) begin errors++; $display("FAIL stream_starve got=%b exp=0", C_STARVE_O); end
    checks++; if (both_ack_cnt != 0 || long_ack_cnt != 0)
      begin errors++; $display("FAIL stream_ack_protocol both=%0d long=%0d exp=0/0", both_ack_cnt, long_ack_cnt); end
  endtask

  task automatic test_starvation;
    int lat, starve_at;
    tm_v_adr = 13'(  $urandom); tm_v_cyc = 1'b1; tm_v_stb = 1'b1;
    tick(3);
    checks++; if (tm_c_starve !== 1'b0) begin errors++; $display("FAIL starve_pre got=%b exp=0", tm_c_starve); end
    tm_c_adr = 13'h055; tm_c_we = 1'b1; tm_c_sel = 2'b11; tm_c_dat_i = 16'h7777;
    tm_c_cyc = 1'b1; tm_c_stb = 1'b1;
    lat = 0; starve_at = -1;
    while (lat < 60) begin
      @(posedge CLK_I); #1;
      lat++;
      if (tm_c_starve === 1'b1 && starve_at < 0) starve_at = lat;
      if (tm_c_ack === 1'b1) break;
    end
    tm_c_cyc = 1'b0; tm_c_stb = 1'b0; tm_c_we = 1'b0;
    tm_v_cyc = 1'b0; tm_v_stb = 1'b0;
    checks++; if (lat != MAX_WAIT + 1) begin errors++; $display("FAIL starve_override_latency got=%0d exp=%0d", lat, MAX_WAIT + 1); end
    checks++; if (starve_at != MAX_WAIT) begin errors++; $display("FAIL starve_flag_cycle got=%0d exp=%0d", starve_at, MAX_WAIT); end
    tick(2);
    checks++; if (tm_c_starve !== 1'b1) begin errors++; $display("FAIL starve_sticky got=%b exp=1", tm_c_starve); end
    // The override write must have landed.
    tm_c_adr = 13'h055; tm_c_we = 1'b0; tm_c_cyc = 1'b1; tm_c_stb = 1'b1;
    tick(1);
    tm_c_cyc = 1'b0; tm_c_stb = 1'b0;
    checks++; if (tm_c_ack !== 1'b1 || tm_c_dat_o !== 16'h7777)
      begin errors++; $display("FAIL starve_write_data ack=%b got=%h exp=1/7777", tm_c_ack, tm_c_dat_o); end
    tick(1);
  endtask

  task automatic test_reset_mid;
    logic [15:0] rd; int lat;
    cpu_xfer(1'b1, 13'd7, 2'b11, 16'h5A5A, rd, lat); tick(1);
    cpu_xfer(1'b0, 13'd7, 2'b11, 16'h0, rd, lat); tick(1);
    C_ADR_I = 13'd7; C_WE_I = 1'b1; C_SEL_I = 2'b11; C_DAT_I = 16'hFFFF;
    C_CYC_I = 1'b1; C_STB_I = 1'b1;
    V_ADR_I = 13'h300; V_CYC_I = 1'b1; V_STB_I = 1'b1;
    RST_I = 1'b1;
    @(posedge CLK_I); #1;
    C_CYC_I = 1'b0; C_STB_I = 1'b0; C_WE_I = 1'b0; V_CYC_I = 1'b0; V_STB_I = 1'b0;
    checks++; if (C_ACK_O !== 1'b0 || V_ACK_O !== 1'b0)
      begin errors++; $display("FAIL midrst_acks got=%b%b exp=00", V_ACK_O, C_ACK_O); end
    checks++; if (C_DAT_O !== 16'h0 || V_DAT_O !== 16'h0)
      begin errors++; $display("FAIL midrst_dat got=%h/%h exp=0000/0000", V_DAT_O, C_DAT_O); end
    checks++; if (C_STARVE_O !== 1'b0 || tm_c_starve !== 1'b0)
      begin errors++; $display("FAIL midrst_starve got=%b/%b exp=0/0", C_STARVE_O, tm_c_starve); end
    RST_I = 1'b0;
    tick(1);
    cpu_xfer(1'b0, 13'd7, 2'b11, 16'h0, rd, lat); tick(1);
    checks++; if (rd !== 16'h5A5A) begin errors++; $display("FAIL midrst_write_suppressed got=%h exp=5a5a", rd); end
  endtask

  task automatic test_abort;
    logic [15:0] rd; int lat;
    C_ADR_I = 13'd9; C_WE_I = 1'b1; C_SEL_I = 2'b11; C_DAT_I = 16'h1357;
    C_CYC_I = 1'b1; C_STB_I = 1'b1;
    @(posedge CLK_I); #1;
    C_CYC_I = 1'b0; C_STB_I = 1'b0; C_WE_I = 1'b0;
    checks++; if (C_ACK_O !== 1'b1) begin errors++; $display("FAIL abort_ack got=%b exp=1", C_ACK_O); end
    @(posedge CLK_I); #1;
    checks++; if (C_ACK_O !== 1'b0) begin errors++; $display("FAIL abort_ack_once got=%b exp=0", C_ACK_O); end
    model_mem[9] = 16'h1357;
    cpu_xfer(1'b0, 13'd9, 2'b11, 16'h0, rd, lat);
    checks++; if (lat != 1 || rd !== 16'h1357)
      begin errors++; $display("FAIL abort_next_req lat=%0d got=%h exp=1/1357", lat, rd); end
    tick(1);
  endtask

  task automatic test_random;
    logic [15:0] rd; int lat;
    int cbad, vbad;
    for (int i = 0; i < 16; i++) begin
      cpu_xfer(1'b1, 13'h100 + 13'(i), 2'b11, 16'($urandom), rd, lat); tick(1);
      cpu_xfer(1'b1, 13'h200 + 13'(i), 2'b11, 16'($urandom), rd, lat); tick(1);
    end
    cbad = 0; vbad = 0; both_ack_cnt = 0; long_ack_cnt = 0;
    fork
      begin
        logic [AW-1:0] a; logic w; logic [1:0] s; logic [15:0] d, crd; int cl;
        for (int i = 0; i < 60; i++) begin
          a = 13'h200 + 13'($urandom_range(0, 15));
          w = 1'($urandom_range(0, 1));
          s = 2'($urandom_range(0, 3));
          d = 16'($urandom);
          cpu_xfer(w, a, s, d, crd, cl);
          if (!w && crd !== model_mem[a]) cbad++;
          tick($urandom_range(0, 2));
        end
      end
      begin
        logic [AW-1:0] a; logic [15:0] vrd; int vl;
        for (int i = 0; i < 60; i++) begin
          a = 13'h100 + 13'($urandom_range(0, 15));
          vid_read(a, vrd, vl);
          if (vrd !== model_mem[a]) vbad++;
          tick($urandom_range(0, 2));
        end
      end
    join
    tick(1);
    checks++; if (cbad != 0) begin errors++; $display("FAIL random_cpu_data bad=%0d exp=0", cbad); end
    checks++; if (vbad != 0) begin errors++; $display("FAIL random_vid_data bad=%0d exp=0", vbad); end
    checks++; if (both_ack_cnt != 0 || long_ack_cnt != 0)
      begin errors++; $display("FAIL random_ack_protocol both=%0d long=%0d exp=0/0", both_ack_cnt, long_ack_cnt); end
    checks++; if (C_STARVE_O !== 1'b0) begin errors++; $display("FAIL random_starve got=%b exp=0", C_STARVE_O); end
  endtask

  initial begin
    RST_I = 1'b1;
    V_ADR_I = '0; V_CYC_I = 1'b0; V_STB_I = 1'b0;
    C_ADR_I = '0; C_CYC_I = 1'b0; C_STB_I = 1'b0; C_WE_I = 1'b0; C_SEL_I = 2'b00; C_DAT_I = '0;
    tm_v_adr = '0; tm_v_cyc = 1'b0; tm_v_stb = 1'b0;
    tm_c_adr = '0; tm_c_cyc = 1'b0; tm_c_stb = 1'b0; tm_c_we = 1'b0; tm_c_sel = 2'b00; tm_c_dat_i = '0;
    #1;
    test_reset;
    test_cpu_basic;
    test_byte_lanes;
    test_simultaneous;
    test_video_stream;
    test_starvation;
    test_reset_mid;
    test_abort;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
